led_arbiter: RTL and testbench

Shares the 3-bit LED bank between NREQ requesters, each supplying a pattern and an optional blink flag.
- Arbitration: round-robin, with a minimum hold of HOLD_TICKS prescaler ticks per grant.
- Timebase: an internal free-running prescaler produces the tick.
- Placement: sits between the status sources and the board LED pins, replacing direct per-source LED drive.

---
 rtl/led_arb_pkg.sv | 21 ++
 rtl/led_rr_pick.sv | 38 +++
 rtl/led_arbiter.sv | 143 ++++++++++++++
 tb/tb_led_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and helpers for the LED bank arbiter.
// The pattern-slice helper works on a fixed-width bus that callers zero-pad.
package led_arb_pkg;

    localparam int LED_W    = 3;
    localparam int MAX_NREQ = 32;

    typedef logic [0:0]       arb_state_t;
    typedef logic [LED_W-1:0] led_vec_t;

    localparam arb_state_t ST_IDLE  = 1'b0;
    localparam arb_state_t ST_GRANT = 1'b1;

    function automatic led_vec_t patternSlice(
        input logic [LED_W*MAX_NREQ-1:0] vec,
        input int unsigned               idx
    );
        return vec[idx*LED_W +: LED_W];
    endfunction

endpackage

// File: rtl/led_rr_pick.sv
// Combinational round-robin selector: first set request at or after the
// pointer (mod NREQ), optionally skipping one index.
module led_rr_pick
    import led_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    input  logic [IW-1:0]   excl_i,
    input  logic            exclEn_i,
    output logic            valid_o,
    output logic [IW-1:0]   idx_o
);

    int            cand;
    logic [IW-1:0] candIdx;

    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = int'(ptr_i) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            candIdx = IW'(cand);
            if (!valid_o && req_i[candIdx] && !(exclEn_i && (excl_i == candIdx))) begin
                valid_o = 1'b1;
                idx_o   = candIdx;
            end
        end
    end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin owner of the 3-bit LED bank with a prescaler-timed minimum hold
// and per-requester blink; all outputs are registered or register-derived.
module led_arbiter
    import led_arb_pkg::*;
#(
    parameter int         NREQ         = 4,
    parameter int         TICK_DIV     = 21,
    parameter int         HOLD_TICKS   = 8,
    parameter logic [2:0] IDLE_PATTERN = 3'b000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [LED_W*NREQ-1:0] pattern,
    input  logic [NREQ-1:0]       blink,
    output logic [NREQ-1:0]       grant,
    output logic [0:LED_W-1]      led,
    output logic                  tick
);

    localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int            HW       = $clog2(HOLD_TICKS + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    logic [TICK_DIV-1:0] prescale_q;
    arb_state_t          state_q, state_d;
    logic [IW-1:0]       gIdx_q, gIdx_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                phase_q, phase_d;
    led_vec_t            led_q, led_d;
    logic [NREQ-1:0]     grant_q, grant_d;

    logic                    tickNow;
    logic [LED_W*MAX_NREQ-1:0] patternWide;
    logic [IW-1:0]           nextPtr;
    logic [IW-1:0]           pickPtr;
    logic                    pickValid;
    logic [IW-1:0]           pickIdx;
    logic [NREQ-1:0]         gMask;
    logic                    othersPending;
    logic                    releaseNow;

    assign tickNow = &prescale_q;
    assign tick    = tickNow;
    assign grant   = grant_q;
    assign led     = led_q;

    always_comb begin
        patternWide                   = '0;
        patternWide[LED_W*NREQ-1:0]   = pattern;
    end

    assign nextPtr       = (gIdx_q == LAST_IDX) ? '0 : gIdx_q + IW'(1);
    assign gMask         = NREQ'(1) << gIdx_q;
    assign othersPending = |(req & ~gMask);
    assign releaseNow    = (state_q == ST_GRANT) &&
                           (!req[gIdx_q] || ((hold_q == HOLD_MAX) && othersPending));

    // One picker serves both the idle pick and the handover that skips the owner.
    assign pickPtr = (state_q == ST_IDLE) ? ptr_q : nextPtr;

    led_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (req),
        .ptr_i    (pickPtr),
        .excl_i   (gIdx_q),
        .exclEn_i (state_q == ST_GRANT),
        .valid_o  (pickValid),
        .idx_o    (pickIdx)
    );

    always_comb begin
        state_d = state_q;
        gIdx_d  = gIdx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        phase_d = phase_q;
        led_d   = led_q;
        grant_d = grant_q;

        if (state_q == ST_IDLE) begin
            led_d   = IDLE_PATTERN;
            grant_d = '0;
            if (pickValid) begin
                state_d = ST_GRANT;
                gIdx_d  = pickIdx;
                hold_d  = '0;
                phase_d = 1'b0;
                led_d   = patternSlice(patternWide, 32'(pickIdx));
                grant_d = NREQ'(1) << pickIdx;
            end
        end else if (releaseNow) begin
            ptr_d = nextPtr;
            if (pickValid) begin
                gIdx_d  = pickIdx;
                hold_d  = '0;
                phase_d = 1'b0;
                led_d   = patternSlice(patternWide, 32'(pickIdx));
                grant_d = NREQ'(1) << pickIdx;
            end else begin
                state_d = ST_IDLE;
                led_d   = IDLE_PATTERN;
                grant_d = '0;
            end
        end else begin
            led_d = patternSlice(patternWide, 32'(gIdx_q)) ^
                    {LED_W{phase_q & blink[gIdx_q]}};
            if (tickNow) begin
                phase_d = ~phase_q;
                if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + HW'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            prescale_q <= '0;
            state_q    <= ST_IDLE;
            gIdx_q     <= '0;
            ptr_q      <= '0;
            hold_q     <= '0;
            phase_q    <= 1'b0;
            led_q      <= IDLE_PATTERN;
            grant_q    <= '0;
        end else begin
            prescale_q <= prescale_q + TICK_DIV'(1);
            state_q    <= state_d;
            gIdx_q     <= gIdx_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            phase_q    <= phase_d;
            led_q      <= led_d;
            grant_q    <= grant_d;
        end
    end

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter: vector table, directed multi-cycle
// sequences and random traffic against a behavioural arbitration model.
module tb_led_arbiter;

    localparam int         NREQ       = 4;
    localparam int         TICK_DIV   = 2;
    localparam int         HOLD_TICKS = 2;
    localparam logic [2:0] IDLE_PAT   = 3'b000;
    localparam int         TICK_LAST  = (1 << TICK_DIV) - 1;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] pattern;
    logic [3:0]  blink;
    logic [3:0]  grant;
    logic [0:2]  led;
    logic        tick;

    int nCompared   = 0;
    int nMismatched = 0;

    // Behavioural model state
    int         mCnt;
    int         mG;
    int         mHold;
    int         mPtr;
    bit         mBusy;
    bit         mPhase;
    logic [2:0] mLed;

    typedef struct {
        logic [3:0]  req;
        logic [11:0] pat;
        logic [3:0]  blink;
        logic [3:0]  expGrant;
        logic [2:0]  expLed;
    } vec_t;

    vec_t vecs[6];

    led_arbiter #(
        .NREQ         (NREQ),
        .TICK_DIV     (TICK_DIV),
        .HOLD_TICKS   (HOLD_TICKS),
        .IDLE_PATTERN (IDLE_PAT)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .pattern (pattern),
        .blink   (blink),
        .grant   (grant),
        .led     (led),
        .tick    (tick)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic noteTimeout(input string name);
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] r,
                                 input logic [11:0] p, input logic [3:0] b);
        reset   = rst;
        req     = r;
        pattern = p;
        blink   = b;
    endtask

    function automatic int pickReq(input int start, input int excl);
        for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (start + k) % NREQ;
            if (req[c] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic logic [2:0] patOf(input int i);
        return pattern[3*i +: 3];
    endfunction

    task automatic modelEdge();
        bit tickNow;
        bit others;
        int s;
        if (reset) begin
            mCnt = 0; mBusy = 0; mG = 0; mHold = 0; mPhase = 0; mPtr = 0;
            mLed = IDLE_PAT;
            return;
        end
        tickNow = (mCnt == TICK_LAST);
        mCnt    = (mCnt + 1) % (TICK_LAST + 1);
        if (!mBusy) begin
            s = pickReq(mPtr, -1);
            if (s >= 0) begin
                mBusy = 1; mG = s; mHold = 0; mPhase = 0; mLed = patOf(s);
            end else begin
                mLed = IDLE_PAT;
            end
        end else begin
            others = 0;
            for (int j = 0; j < NREQ; j++) if (j != mG && req[j]) others = 1;
            if (!req[mG] || (mHold == HOLD_TICKS && others)) begin
                mPtr = (mG + 1) % NREQ;
                s = pickReq(mPtr, mG);
                if (s >= 0) begin
                    mG = s; mHold = 0; mPhase = 0; mLed = patOf(s);
                end else begin
                    mBusy = 0; mLed = IDLE_PAT;
                end
            end else begin
                mLed = patOf(mG) ^ ((mPhase && blink[mG]) ? 3'b111 : 3'b000);
                if (tickNow) begin
                    mPhase = !mPhase;
                    if (mHold < HOLD_TICKS) mHold++;
                end
            end
        end
    endtask

    task automatic stepCycle();
        logic [3:0] expGrant;
        @(posedge clock);
        modelEdge();
        #1;
        expGrant = mBusy ? 4'(1 << mG) : 4'b0000;
        checkOutput("model grant", grant, expGrant);
        checkOutput("model led", led, mLed);
        checkOutput("model tick", tick, (mCnt == TICK_LAST));
    endtask

    initial begin
        logic [3:0] prevG;
        logic [3:0] curExp;
        logic [0:2] prevLed;
        int         ticksInGrant;
        int         lastTick;
        int         switches;
        int         toggles;
        bit         found;

        vecs[0] = '{4'b0001, 12'b000_000_000_101, 4'b1111, 4'b0001, 3'b101};
        vecs[1] = '{4'b0110, 12'b111_011_110_001, 4'b0000, 4'b0010, 3'b110};
        vecs[2] = '{4'b1000, 12'b010_000_000_000, 4'b1000, 4'b1000, 3'b010};
        vecs[3] = '{4'b1100, 12'b001_100_000_000, 4'b0000, 4'b0100, 3'b100};
        vecs[4] = '{4'b0000, 12'b111_111_111_111, 4'b1111, 4'b0000, 3'b000};
        vecs[5] = '{4'b1111, 12'b000_000_000_111, 4'b0000, 4'b0001, 3'b111};

        $display("[TB] start");
        applyStimulus(1'b1, 4'b1111, 12'b011_010_001_110, 4'b0000);

        // Reset dominates while every requester is asking
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("t1 reset grant", grant, 4'b0000);
            checkOutput("t1 reset led", led, 3'b000);
            checkOutput("t1 reset tick", tick, 1'b0);
        end
        applyStimulus(1'b0, 4'b1111, 12'b011_010_001_110, 4'b0000);
        stepCycle();
        checkOutput("t1 first grant", grant, 4'b0001);
        checkOutput("t1 first led", led, 3'b110);

        // Idle pick from pointer 0 after reset
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 4'b0000, vecs[i].pat, vecs[i].blink);
            stepCycle();
            applyStimulus(1'b0, vecs[i].req, vecs[i].pat, vecs[i].blink);
            stepCycle();
            checkOutput($sformatf("vec%0d grant", i), grant, vecs[i].expGrant);
            checkOutput($sformatf("vec%0d led", i), led, vecs[i].expLed);
        end

        // Single requester then drop
        applyStimulus(1'b1, 4'b0000, 12'b000_101_000_000, 4'b0000);
        stepCycle();
        applyStimulus(1'b0, 4'b0100, 12'b000_101_000_000, 4'b0000);
        stepCycle();
        checkOutput("t2 grant", grant, 4'b0100);
        checkOutput("t2 led", led, 3'b101);
        applyStimulus(1'b0, 4'b0000, 12'b000_101_000_000, 4'b0000);
        stepCycle();
        checkOutput("t2 drop grant", grant, 4'b0000);
        checkOutput("t2 drop led", led, 3'b000);

        // Two contenders alternate, each held until one cycle past its 2nd tick
        applyStimulus(1'b1, 4'b0000, 12'b101_000_011_000, 4'b0000);
        stepCycle();
        applyStimulus(1'b0, 4'b1010, 12'b101_000_011_000, 4'b0000);
        stepCycle();
        checkOutput("t3 first grant", grant, 4'b0010);
        prevG        = 4'b0010;
        curExp       = 4'b0010;
        ticksInGrant = tick ? 1 : 0;
        lastTick     = tick ? 0 : -10;
        switches     = 0;
        for (int cyc = 1; cyc < 60; cyc++) begin
            stepCycle();
            if (grant !== prevG) begin
                curExp = (curExp == 4'b0010) ? 4'b1000 : 4'b0010;
                checkOutput("t3 next grant", grant, curExp);
                checkOutput("t3 ticks held", ticksInGrant, 2);
                checkOutput("t3 release lag", cyc - lastTick, 2);
                switches++;
                ticksInGrant = 0;
                prevG = grant;
            end
            if (tick) begin
                ticksInGrant++;
                lastTick = cyc;
            end
        end
        checkOutput("t3 switch count", (switches >= 5), 1'b1);

        // Lone blinking requester keeps the grant indefinitely
        applyStimulus(1'b1, 4'b0000, 12'b000_000_000_110, 4'b0001);
        stepCycle();
        applyStimulus(1'b0, 4'b0001, 12'b000_000_000_110, 4'b0001);
        stepCycle();
        checkOutput("t4 first led", led, 3'b110);
        prevLed = led;
        toggles = 0;
        for (int i = 0; i < 24; i++) begin
            stepCycle();
            checkOutput("t4 grant", grant, 4'b0001);
            checkOutput("t4 led value", (led == 3'b110 || led == 3'b001), 1'b1);
            if (led !== prevLed) toggles++;
            prevLed = led;
        end
        checkOutput("t4 toggles", (toggles >= 4), 1'b1);

        // Owner drops at hold=1 while another waits
        applyStimulus(1'b1, 4'b0000, 12'b000_011_000_100, 4'b0000);
        stepCycle();
        applyStimulus(1'b0, 4'b0001, 12'b000_011_000_100, 4'b0000);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            stepCycle();
            if (mBusy && mG == 0 && mHold == 1) found = 1;
        end
        if (!found) noteTimeout("t5 reach hold1");
        applyStimulus(1'b0, 4'b0100, 12'b000_011_000_100, 4'b0000);
        stepCycle();
        checkOutput("t5 handover grant", grant, 4'b0100);
        checkOutput("t5 handover led", led, 3'b011);
        applyStimulus(1'b0, 4'b0110, 12'b000_011_000_100, 4'b0000);
        for (int i = 0; i < 10; i++) stepCycle();

        // Reset mid-grant while blinking, pointer moved off 0
        applyStimulus(1'b1, 4'b0000, 12'b111_000_101_010, 4'b1111);
        stepCycle();
        applyStimulus(1'b0, 4'b0110, 12'b111_000_101_010, 4'b1111);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            stepCycle();
            if (mBusy && mG == 2 && mPhase) found = 1;
        end
        if (!found) noteTimeout("t6 reach grant2");
        applyStimulus(1'b1, 4'b1111, 12'b111_000_101_010, 4'b1111);
        stepCycle();
        checkOutput("t6 reset grant", grant, 4'b0000);
        checkOutput("t6 reset led", led, 3'b000);
        applyStimulus(1'b0, 4'b1111, 12'b111_000_101_010, 4'b1111);
        stepCycle();
        checkOutput("t6 restart grant", grant, 4'b0001);
        checkOutput("t6 restart led", led, 3'b010);

        // Random traffic against the model
        for (int i = 0; i < 500; i++) begin
            logic       rst;
            logic [3:0] r;
            logic [11:0] p;
            logic [3:0] b;
            rst = ($urandom_range(0, 59) == 0);
            r   = ($urandom_range(0, 6) == 0) ? 4'($urandom) : req;
            p   = ($urandom_range(0, 9) == 0) ? 12'($urandom) : pattern;
            b   = ($urandom_range(0, 9) == 0) ? 4'($urandom) : blink;
            applyStimulus(rst, r, p, b);
            stepCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
